fetch_prefetch_queue: RTL
=========================

# fetch_prefetch_queue

Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register. Generates the sequential fetch PC, issues word requests to a variable-latency instruction memory, and buffers returned instructions in a DEPTH-entry in-order queue. Presents one instruction per cycle with the ARM-style PC (fetch address + 4). Handles freeze from the hazard logic and branch redirect with squash of in-flight responses.

## Interface
- DEPTH, 4: queue entries and maximum in-flight requests combined; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- freeze  in  1  downstream stall; hold the presented instruction, no pop.
- Branch_taken  in  1  redirect request from EXE; one-cycle pulse.
- BranchAddr  in  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word-aligned request address.
- imem_ready  in  1  memory accepts request this cycle when high with imem_req.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- valid  out  1  PC/Instruction hold a real instruction.
- PC  out  32  address of presented instruction + 4.
- Instruction  out  32  presented instruction; 32'h0 when valid=0.

## Operation
- State: fetch_pc (32), queue storage DEPTH×(addr,instr), rd/wr pointers, occupancy count (0..DEPTH), outstanding count (0..DEPTH), drop count (0..DEPTH).
- Issue: imem_req = !rst && !Branch_taken && (occupancy + outstanding < DEPTH); imem_addr = fetch_pc. Accept = imem_req && imem_ready → fetch_pc += 4 (wraps modulo 2^32), outstanding += 1, request address recorded in an in-order tag FIFO (or equivalent) for the response.
- Response: on imem_rvalid, outstanding −= 1. If drop > 0: discard, drop −= 1. Else push {addr, imem_rdata} at wr pointer.
- Present: head entry drives outputs; valid = occupancy ≠ 0; PC = head addr + 4; Instruction = head instr, else 0.
- Pop: valid && !freeze && !Branch_taken → rd pointer advances, occupancy −= 1.
- Push and pop in same cycle: occupancy unchanged, both pointers advance. Overflow impossible by credit rule; an rvalid with outstanding = 0 is an environment error (assert in bench).
- Redirect (Branch_taken=1, overrides freeze): fetch_pc ← {BranchAddr[31:2],2'b00}; queue cleared (occupancy 0, pointers equal); no request issued; drop ← outstanding − imem_rvalid (all remaining in-flight responses squashed); a response arriving this same cycle is discarded.
- Back-to-back redirects: later one wins; drop recomputed from current outstanding.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst high at edge): fetch_pc=0, occupancy=0, outstanding=0, drop=0, pointers 0. During rst: imem_req=0, valid=0, PC=4 (don't-care, driven as head addr+4 of zeroed entry), Instruction=0.
- First cycle after rst deasserts: imem_req=1, imem_addr=0.
- Latency: request accepted at cycle t, response at t+L (L≥1), valid at t+L+1 (no rvalid→output bypass).
- Zero-wait memory (imem_ready=1, L=1) sustains one instruction per cycle once queue is primed.
- Redirect at cycle t: valid=0 at t+1; first request to target issued at t+1; earliest target instruction valid at t+3.
- Reset asserted mid-operation: all in-flight responses arriving after reset release are not squashed by drop (drop=0); memory must also be reset together.

## Test plan
- Reset then imem_ready=1, L=1, freeze=0: addresses 0,4,8,… issued each cycle; valid from cycle 3 on, PC=4,8,12,… with matching instructions, no gaps.
- freeze held 5 cycles with DEPTH=4: output held stable; occupancy reaches 4, imem_req drops to 0 once occupancy+outstanding=4; release → stream resumes, no lost or duplicated instruction.
- L=3, imem_ready=1: at most 4 in flight; steady state never exceeds DEPTH; ordering preserved.
- Branch_taken with BranchAddr=0x103 while 3 responses outstanding: next valid instruction has PC=0x104, the 3 stale responses discarded, imem_addr=0x100 next cycle.
- Branch_taken while freeze=1 and imem_rvalid=1 same cycle: queue empties, response dropped, drop=outstanding−1, valid=0 next cycle.
- imem_ready toggling randomly and fetch_pc reaching 0xFFFFFFFC: wraps to 0; PC output for that instruction = 0x00000000.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited word requests
// to a variable-latency memory and a DEPTH-entry in-order prefetch queue with redirect squash.
module fetch_prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] BranchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] PC,
  output logic [31:0] Instruction
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] occ_reg, occ_next;
  logic [CW-1:0] out_reg, out_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] tag_rd_reg, tag_rd_next;
  logic [AW-1:0] tag_wr_reg, tag_wr_next;

  logic [31:0] addr_q  [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [31:0] tag_q   [DEPTH];

  logic [SW-1:0] credit_used;
  logic          accept;
  logic          rsp_keep;
  logic          pop;

  // Queue slots plus in-flight requests share one credit pool, so a returning
  // response always has a free slot waiting for it.
  assign credit_used = SW'(occ_reg) + SW'(out_reg);
  assign imem_req    = !rst && !Branch_taken && (credit_used < SW'(DEPTH));
  assign imem_addr   = fetch_pc_reg;
  assign accept      = imem_req && imem_ready;
  assign rsp_keep    = imem_rvalid && !Branch_taken && (drop_reg == '0);

  assign valid       = !rst && (occ_reg != '0);
  assign pop         = valid && !freeze && !Branch_taken;
  assign PC          = addr_q[rd_ptr_reg] + 32'd4;
  assign Instruction = valid ? instr_q[rd_ptr_reg] : 32'h0;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    occ_next      = occ_reg;
    out_next      = out_reg + CW'(accept) - CW'(imem_rvalid);
    drop_next     = drop_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    tag_wr_next   = tag_wr_reg;
    tag_rd_next   = tag_rd_reg;

    if (accept) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
      tag_wr_next   = tag_wr_reg + AW'(1);
    end
    if (imem_rvalid) begin
      tag_rd_next = tag_rd_reg + AW'(1);
    end

    if (Branch_taken) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_next = BranchAddr & ~32'h3;
      drop_next     = out_reg - CW'(imem_rvalid);
      occ_next      = '0;
      rd_ptr_next   = wr_ptr_reg;
    end else begin
      if (imem_rvalid && (drop_reg != '0)) begin
        drop_next = drop_reg - CW'(1);
      end
      if (rsp_keep) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      occ_next = occ_reg + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= '0;
      occ_reg      <= '0;
      out_reg      <= '0;
      drop_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      tag_rd_reg   <= '0;
      tag_wr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      occ_reg      <= occ_next;
      out_reg      <= out_next;
      drop_reg     <= drop_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      tag_rd_reg   <= tag_rd_next;
      tag_wr_reg   <= tag_wr_next;
    end
  end

  // Request-address tags, consumed in order as responses return.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[tag_wr_reg] <= fetch_pc_reg;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        addr_q[gi]  <= '0;
        instr_q[gi] <= '0;
      end else if (rsp_keep && (wr_ptr_reg == AW'(gi))) begin
        addr_q[gi]  <= tag_q[tag_rd_reg];
        instr_q[gi] <= imem_rdata;
      end
    end
  end

endmodule
